// File: rtl/mpram_lvt_clr.sv
// Multi-ported RAM: one bank per write port, a live-value table picks the newest bank.
// Hardware clear sweep on start-up/clr_req; optional conflict statistics via MPRAM_CONF_STATS_EN.
module mpram_lvt_clr #(
  parameter  int MEMD    = 16,
  parameter  int DATAW   = 32,
  parameter  int nRPORTS = 2,
  parameter  int nWPORTS = 2,
  parameter  int RDW     = 0,
  localparam int ADDRW   = (MEMD > 1) ? $clog2(MEMD) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_req,
  output logic                       ready,
  input  logic [nWPORTS-1:0]         WEnb,
  input  logic [ADDRW*nWPORTS-1:0]   WAddr,
  input  logic [DATAW*nWPORTS-1:0]   WData,
  input  logic [ADDRW*nRPORTS-1:0]   RAddr,
  output logic [DATAW*nRPORTS-1:0]   RData,
  output logic [nRPORTS-1:0]         RValid,
  output logic [nWPORTS-1:0]         wconf
`ifdef MPRAM_CONF_STATS_EN
  ,
  input  logic                       conf_clr,
  output logic [15:0]                conf_cnt
`endif
);

  localparam int LVTW = (nWPORTS > 1) ? $clog2(nWPORTS) : 1;
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(MEMD - 1);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e             state_q;
  logic [ADDRW-1:0]   clr_addr_q;
  logic [DATAW-1:0]   bank_q [nWPORTS][MEMD];
  logic [LVTW-1:0]    lvt_q [MEMD];
  logic [DATAW-1:0]   rdata_q [nRPORTS];
  logic [DATAW-1:0]   rdata_d [nRPORTS];
  logic [nRPORTS-1:0] rvalid_q;
  logic [nWPORTS-1:0] wconf_q;
  logic [nWPORTS-1:0] wconf_d;

  logic [ADDRW-1:0]   wa [nWPORTS];
  logic [DATAW-1:0]   wd [nWPORTS];
  logic [ADDRW-1:0]   ra [nRPORTS];
  logic [nWPORTS-1:0] lose;
  logic [nWPORTS-1:0] win;
  logic               in_ready;

  function automatic logic in_range(input logic [ADDRW-1:0] a);
    return {1'b0, a} < (ADDRW+1)'(MEMD);
  endfunction

  assign in_ready = (state_q == S_READY);

  always_comb begin
    for (int i = 0; i < nWPORTS; i++) begin
      wa[i] = WAddr[i*ADDRW +: ADDRW];
      wd[i] = WData[i*DATAW +: DATAW];
    end
    for (int j = 0; j < nRPORTS; j++) begin
      ra[j] = RAddr[j*ADDRW +: ADDRW];
    end
  end

  // A port loses when any higher-index enabled port targets the same address.
  always_comb begin
    lose = '0;
    win  = '0;
    for (int i = 0; i < nWPORTS; i++) begin
      for (int k = i + 1; k < nWPORTS; k++) begin
        if (WEnb[i] && WEnb[k] && (wa[i] == wa[k])) lose[i] = 1'b1;
      end
    end
    for (int i = 0; i < nWPORTS; i++) begin
      win[i] = in_ready && WEnb[i] && !lose[i] && in_range(wa[i]);
    end
    wconf_d = in_ready ? (lose & WEnb) : '0;
  end

  always_comb begin
    for (int j = 0; j < nRPORTS; j++) begin
      rdata_d[j] = '0;
      if (in_range(ra[j])) rdata_d[j] = bank_q[lvt_q[ra[j]]][ra[j]];
      if (RDW != 0) begin
        for (int i = 0; i < nWPORTS; i++) begin
          if (win[i] && (wa[i] == ra[j])) rdata_d[j] = wd[i];
        end
      end
    end
  end

  // Storage is deliberately not reset; the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_CLEAR) begin
        bank_q[0][clr_addr_q] <= '0;
        lvt_q[clr_addr_q]     <= '0;
      end else begin
        for (int i = 0; i < nWPORTS; i++) begin
          if (win[i]) begin
            bank_q[i][wa[i]] <= wd[i];
            lvt_q[wa[i]]     <= LVTW'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      rdata_q    <= '{default: '0};
      rvalid_q   <= '0;
      wconf_q    <= '0;
    end else begin
      wconf_q <= wconf_d;
      case (state_q)
        S_CLEAR: begin
          rvalid_q <= '0;
          rdata_q  <= '{default: '0};
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= S_READY;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDRW'(1);
          end
        end
        S_READY: begin
          rvalid_q <= '1;
          rdata_q  <= rdata_d;
          if (clr_req) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
          end
        end
        default: begin
          state_q    <= S_CLEAR;
          clr_addr_q <= '0;
        end
      endcase
    end
  end

`ifdef MPRAM_CONF_STATS_EN
  logic [15:0] conf_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || conf_clr) begin
      conf_cnt_q <= '0;
    end else if ((|wconf_d) && (conf_cnt_q != 16'hFFFF)) begin
      conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end

  assign conf_cnt = conf_cnt_q;
`endif

  always_comb begin
    RData = '0;
    for (int j = 0; j < nRPORTS; j++) begin
      RData[j*DATAW +: DATAW] = rdata_q[j];
    end
  end

  assign ready  = in_ready;
  assign RValid = rvalid_q;
  assign wconf  = wconf_q;

endmodule

// File: tb/tb_mpram_lvt_clr.sv
// Directed bench for mpram_lvt_clr: two instances (old-data and bypass read-during-write)
// share stimulus; expected values are hand-computed constants.
module tb_mpram_lvt_clr;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic [1:0]  WEnb;
  logic [7:0]  WAddr;
  logic [63:0] WData;
  logic [7:0]  RAddr;

  logic        ready0, ready1;
  logic [63:0] rdata0, rdata1;
  logic [1:0]  rvalid0, rvalid1;
  logic [1:0]  wconf0, wconf1;
`ifdef MPRAM_CONF_STATS_EN
  logic        conf_clr;
  logic [15:0] conf_cnt0, conf_cnt1;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cnt;

  mpram_lvt_clr #(.MEMD(16), .DATAW(32), .nRPORTS(2), .nWPORTS(2), .RDW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready0),
    .WEnb(WEnb), .WAddr(WAddr), .WData(WData), .RAddr(RAddr),
    .RData(rdata0), .RValid(rvalid0), .wconf(wconf0)
`ifdef MPRAM_CONF_STATS_EN
    , .conf_clr(conf_clr), .conf_cnt(conf_cnt0)
`endif
  );

  mpram_lvt_clr #(.MEMD(16), .DATAW(32), .nRPORTS(2), .nWPORTS(2), .RDW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready1),
    .WEnb(WEnb), .WAddr(WAddr), .WData(WData), .RAddr(RAddr),
    .RData(rdata1), .RValid(rvalid1), .wconf(wconf1)
`ifdef MPRAM_CONF_STATS_EN
    , .conf_clr(conf_clr), .conf_cnt(conf_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    clr_req = 1'b0;
    WEnb    = '0;
    WAddr   = '0;
    WData   = '0;
    RAddr   = '0;
`ifdef MPRAM_CONF_STATS_EN
    conf_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_ready",  {63'd0, ready0}, 64'd0);
    chk("rst_rvalid", {62'd0, rvalid0}, 64'd0);
    chk("rst_rdata",  rdata0, 64'd0);
    chk("rst_wconf",  {62'd0, wconf0}, 64'd0);

    // start-up sweep
    rst_n = 1'b1;
    cnt = 0;
    while (!ready0 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("sweep_len", 64'(cnt), 64'd16);
    chk("sweep_rdy1", {63'd0, ready1}, 64'd1);
    for (int a = 0; a < 16; a++) begin
      RAddr = {4'(a), 4'(a)};
      tick();
      chk("init_rd", rdata0, 64'd0);
      chk("init_rv", {62'd0, rvalid0}, 64'd3);
    end

    // sequential overwrite of addr 3 by two ports
    WEnb = 2'b01; WAddr = {4'd0, 4'd3}; WData = {32'h0, 32'hAAAA0001};
    tick();
    WEnb = 2'b10; WAddr = {4'd3, 4'd0}; WData = {32'hBBBB0002, 32'h0}; RAddr = {4'd3, 4'd3};
    tick();
    chk("seq_rdw0", rdata0, {2{32'hAAAA0001}});
    chk("seq_rdw1", rdata1, {2{32'hBBBB0002}});
    WEnb = 2'b00;
    tick();
    chk("seq_rd", rdata0, {2{32'hBBBB0002}});

    // same-address conflict
    WEnb = 2'b11; WAddr = {4'd5, 4'd5}; WData = {32'h22, 32'h11}; RAddr = '0;
    tick();
    chk("conf_pulse", {62'd0, wconf0}, 64'd1);
`ifdef MPRAM_CONF_STATS_EN
    chk("conf_cnt1", {48'd0, conf_cnt0}, 64'd1);
`endif
    WEnb = 2'b00; RAddr = {4'd5, 4'd5};
    tick();
    chk("conf_gone", {62'd0, wconf0}, 64'd0);
    chk("conf_rd", rdata0, {2{32'h22}});

    // distinct addresses, no conflict
    WEnb = 2'b11; WAddr = {4'd2, 4'd1}; WData = {32'h200, 32'h100};
    tick();
    chk("noconf", {62'd0, wconf0}, 64'd0);
    WEnb = 2'b00; RAddr = {4'd2, 4'd1};
    tick();
    chk("noconf_rd", rdata0, {32'h200, 32'h100});

    // read-during-write on addr 7
    WEnb = 2'b01; WAddr = {4'd0, 4'd7}; WData = {32'h0, 32'h5};
    tick();
    WEnb = 2'b10; WAddr = {4'd7, 4'd0}; WData = {32'h9, 32'h0}; RAddr = {4'd7, 4'd7};
    tick();
    chk("rdw0", rdata0, {2{32'h5}});
    chk("rdw1", rdata1, {2{32'h9}});
    WEnb = 2'b00;
    tick();
    chk("rdw_after", rdata0, {2{32'h9}});

    // populate via bank 1, then clear on request
    for (int a = 0; a < 16; a++) begin
      WEnb = 2'b10; WAddr = {4'(a), 4'd0}; WData = {32'hC0DE0000 | 32'(a), 32'h0};
      tick();
    end
    WEnb = 2'b00; RAddr = {4'd9, 4'd14};
    tick();
    chk("pop_rd", rdata0, {32'hC0DE0009, 32'hC0DE000E});
    clr_req = 1'b1; WEnb = 2'b01; WAddr = {4'd0, 4'd0}; WData = {32'h0, 32'h77};
    tick();
    clr_req = 1'b0;
    chk("clr_enter", {63'd0, ready0}, 64'd0);
    WEnb = 2'b10; WAddr = {4'd15, 4'd0}; WData = {32'hDEAD, 32'h0}; RAddr = {4'd15, 4'd15};
    cnt = 0;
    while (!ready0 && cnt < 40) begin
      cnt++;
      tick();
      if (cnt == 2) begin
        chk("clr_rvalid", {62'd0, rvalid0}, 64'd0);
        chk("clr_rdata", rdata0, 64'd0);
      end
    end
    chk("clr_len", 64'(cnt), 64'd16);
    WEnb = 2'b00;
    for (int a = 0; a < 16; a++) begin
      RAddr = {4'(a), 4'(15 - a)};
      tick();
      chk("clr_rd", rdata0, 64'd0);
    end

    // reset in the middle of a sweep
    clr_req = 1'b1; WEnb = 2'b11; WAddr = {4'd4, 4'd4}; WData = {32'h44, 32'h33};
    tick();
    clr_req = 1'b0; WEnb = 2'b00;
    repeat (8) tick();
    chk("mid_ready", {63'd0, ready0}, 64'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wconf", {62'd0, wconf0}, 64'd0);
    chk("mid_rst_rv", {62'd0, rvalid0}, 64'd0);
`ifdef MPRAM_CONF_STATS_EN
    chk("mid_rst_cnt", {48'd0, conf_cnt0}, 64'd0);
`endif
    rst_n = 1'b1;
    cnt = 0;
    while (!ready0 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("mid_len", 64'(cnt), 64'd16);
    RAddr = {4'd4, 4'd4};
    tick();
    chk("mid_rd", rdata0, 64'd0);
    chk("mid_rv", {62'd0, rvalid0}, 64'd3);

`ifdef MPRAM_CONF_STATS_EN
    WEnb = 2'b11; WAddr = {4'd6, 4'd6}; conf_clr = 1'b1;
    tick();
    chk("cnt_clr_wins", {48'd0, conf_cnt0}, 64'd0);
    conf_clr = 1'b0;
    tick();
    chk("cnt_inc", {48'd0, conf_cnt0}, 64'd1);
    WEnb = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mpram_lvt_clr.md
Name: mpram_lvt_clr

Overview:
- Multi-ported RAM built from one multi-read bank per write port, with a live-value table (LVT) that selects the most recent bank per address.
- Generalised successor of the plain LVT multiport RAM. Adds:
  - a synchronous active-low reset;
  - a hardware clear sequencer that sweeps every address to zero, at start-up and on request;
  - deterministic same-address write-conflict resolution with a reporting pulse;
  - a registered read-valid qualifier.
- Used as the register-file and map-storage primitive in the sephirot core.

Parameters:
- MEMD, 16: words per bank; any value >= 2, need not be a power of 2.
- DATAW, 32: data width in bits.
- nRPORTS, 2: read ports, 1..8.
- nWPORTS, 2: write ports, 1..8.
- RDW, 0: same-cycle read-during-write policy. 0 = read returns old data; 1 = read returns new data (bypass).
- ADDRW, log2(MEMD): address width, derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr_req  in  1  single-cycle request to re-clear the whole memory.
- ready  out  1  high when the memory accepts reads and writes.
- WEnb  in  nWPORTS  per-port write enable.
- WAddr  in  ADDRW*nWPORTS  write addresses, packed; port i is at [i*ADDRW +: ADDRW].
- WData  in  DATAW*nWPORTS  write data, packed.
- RAddr  in  ADDRW*nRPORTS  read addresses, packed.
- RData  out  DATAW*nRPORTS  read data, registered.
- RValid  out  nRPORTS  high when the RData slice corresponds to an accepted read issued on the previous cycle.
- wconf  out  nWPORTS  one-cycle pulse; bit i set when write port i lost a same-address conflict.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - FSM enters CLEAR with the clear address at 0.
  - ready = 0, RValid = 0, RData = 0, wconf = 0.
  - Bank contents are not touched by reset itself.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 into bank 0 at the clear address and sets the LVT entry to bank 0.
  - Clear address increments by 1 per cycle.
  - After address MEMD-1 is written, the next state is READY.
  - The sweep takes exactly MEMD cycles; ready rises on the cycle after the last clear write.
- In CLEAR:
  - WEnb is ignored.
  - RValid = 0; RData holds 0.
  - clr_req is ignored.
- READY:
  - clr_req = 1 moves the FSM to CLEAR with the clear address at 0 on the next edge.
  - Writes and reads presented in that same cycle are still performed.
- Writes:
  - Port i with WEnb[i] writes WData slice i into bank i at WAddr slice i.
  - The LVT entry for that address is set to i.
  - Write latency is 1; data is readable on the next cycle.
- Write conflict:
  - When two or more enabled ports share an address, the highest-index port wins.
  - Only the winner updates its bank and the LVT; losers' bank writes are suppressed.
  - wconf asserts, registered one cycle later, for every losing port.
- Reads:
  - Latency 1. RData slice j = bank[LVT[RAddr_j]] [RAddr_j] sampled at the edge.
  - RValid[j] = 1 on the cycle after any READY cycle; every read port reads every cycle.
- Read-during-write to the same address in the same cycle:
  - RDW = 0 returns the pre-write value.
  - RDW = 1 returns the winning write's data.
- Reset asserted mid-sweep or mid-operation restarts CLEAR from address 0.
- No partial-write state survives reset.

Optional Feature:
- Macro MPRAM_CONF_STATS_EN.
- When defined:
  - Adds output conf_cnt, 16 bits: saturating count of cycles with at least one conflict.
  - Adds input conf_clr, 1 bit: synchronous clear of conf_cnt.
  - conf_cnt resets to 0; it holds at 0xFFFF when saturated.
  - conf_clr wins over a same-cycle increment.
- When undefined: neither port exists and wconf behaviour is unchanged.

Test Plan (defaults MEMD=16, DATAW=32, 2R/2W):
- Release rst_n, hold clr_req = 0 -> ready rises exactly 16 cycles after the first edge with rst_n = 1; reads of all 16 addresses return 0 with RValid = 1.
- Port0 writes 0xAAAA0001 to addr 3; next cycle port1 writes 0xBBBB0002 to addr 3 -> a read of addr 3 on both read ports returns 0xBBBB0002.
- Both ports write addr 5 in the same cycle (0x11, 0x22) -> addr 5 reads 0x22; wconf = 2'b01 for exactly one cycle.
- RDW = 0 vs RDW = 1: addr 7 holds 0x5; same cycle write 0x9 and read addr 7 -> RData = 0x5 (RDW = 0) or 0x9 (RDW = 1).
- After populating addrs 0..15, pulse clr_req -> ready = 0 for 16 cycles; writes issued during CLEAR are dropped; all addrs then read 0.
- Assert rst_n = 0 at clear address 8, then release -> sweep restarts at 0, ready rises 16 cycles later; with MPRAM_CONF_STATS_EN, conf_cnt reads 0.
